// File: rtl/pd_stage.sv
// rtl/pd_stage.sv - two-wide gshare/BTB/RAS branch prediction stage (optional RAS: PD_RAS_EN)
module pd_stage #(
    parameter int PHT_ADDRESS = 9,
    parameter int GHR_SIZE    = 9,
    parameter int XLEN        = 32,
    parameter int RAS_ADDRESS = 3
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   mispredict,
    input  logic                   actual_taken,
    input  logic [XLEN-1:0]        actual_target_address,
    input  logic [XLEN-1:0]        actual_return_address,
    input  logic [XLEN-1:0]        ex_pc,
    input  logic                   ex_is_branch,
    input  logic                   ex_is_ret,
    input  logic                   update_pht,
    input  logic                   update_btb,
    input  logic                   update_ras,
    input  logic                   restore_ghr,
    input  logic                   restore_ras,
    input  logic [GHR_SIZE-1:0]    ghr_snap,
    input  logic [PHT_ADDRESS-1:0] rb_pht_index,
    input  logic [RAS_ADDRESS-1:0] rb_sp_snap,
    input  logic [2*XLEN-1:0]      rb_ras_snap,
    output logic [XLEN-1:0]        pd_pc,
    output logic                   pd_btb_hit1,
    output logic                   pd_btb_hit2,
    output logic                   pd_pred_taken1,
    output logic                   pd_pred_taken2,
    output logic [XLEN-1:0]        pd_pred_target1,
    output logic [XLEN-1:0]        pd_pred_target2,
    output logic [PHT_ADDRESS-1:0] pd_pht_index1,
    output logic [PHT_ADDRESS-1:0] pd_pht_index2,
    output logic [GHR_SIZE-1:0]    pd_prev_ghr,
    output logic [RAS_ADDRESS-1:0] pd_sp_snap,
    output logic [2*XLEN-1:0]      pd_ras_snap
);
    typedef enum logic [1:0] {BT_BR = 2'd0, BT_JUMP = 2'd1, BT_CALL = 2'd2, BT_RET = 2'd3} btb_type_e;

    localparam int BTB_N = 16;
    localparam int TAG_W = XLEN - 6;
    localparam int PHT_N = 1 << PHT_ADDRESS;

    logic [XLEN-1:0]     pc_q, pc_d;
    logic [GHR_SIZE-1:0] ghr_q, ghr_d, ghr_spec;
    logic                btb_valid_q [BTB_N];
    logic [TAG_W-1:0]    btb_tag_q   [BTB_N];
    logic [XLEN-1:0]     btb_tgt_q   [BTB_N];
    btb_type_e           btb_type_q  [BTB_N];
    btb_type_e           btb_wr_type;
    logic [1:0]          pht_q       [PHT_N];

    logic [XLEN-1:0]        slot_pc     [2];
    logic [3:0]             slot_bidx   [2];
    logic                   slot_hit    [2];
    btb_type_e              slot_type   [2];
    logic [PHT_ADDRESS-1:0] slot_pidx   [2];
    logic                   slot_ctr_hi [2];
    logic                   slot_taken  [2];
    logic [XLEN-1:0]        slot_tgt    [2];

    logic            spec_push, spec_pop;
    logic [XLEN-1:0] spec_push_val;
    logic            unused_pc_lsb;

    assign unused_pc_lsb = ^ex_pc[1:0];

`ifdef PD_RAS_EN
    logic [RAS_ADDRESS-1:0] sp_q, sp_d;
    logic [XLEN-1:0]        ras_q [1 << RAS_ADDRESS];
    logic [RAS_ADDRESS-1:0] sp_m1, sp_m2, snap_m1, snap_m2;
    logic [XLEN-1:0]        ras_top;

    assign sp_m1       = sp_q - RAS_ADDRESS'(1);
    assign sp_m2       = sp_q - RAS_ADDRESS'(2);
    assign snap_m1     = rb_sp_snap - RAS_ADDRESS'(1);
    assign snap_m2     = rb_sp_snap - RAS_ADDRESS'(2);
    assign ras_top     = ras_q[sp_m1];
    assign pd_sp_snap  = sp_q;
    assign pd_ras_snap = {ras_q[sp_m1], ras_q[sp_m2]};

    // Stack pointer: a restore from EX wins over this group's speculative push/pop
    always_comb begin
        sp_d = sp_q;
        if (restore_ras) begin
            if (update_ras)     sp_d = rb_sp_snap + RAS_ADDRESS'(1);
            else if (ex_is_ret) sp_d = snap_m1;
            else                sp_d = rb_sp_snap;
        end else if (!mispredict) begin
            if (spec_push)      sp_d = sp_q + RAS_ADDRESS'(1);
            else if (spec_pop)  sp_d = sp_m1;
        end
    end

    // RAS storage: restore the two top entries, then optionally push the resolved call
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
            for (int i = 0; i < (1 << RAS_ADDRESS); i++) ras_q[i] <= '0;
        end else begin
            sp_q <= sp_d;
            if (restore_ras) begin
                ras_q[snap_m1] <= rb_ras_snap[2*XLEN-1:XLEN];
                ras_q[snap_m2] <= rb_ras_snap[XLEN-1:0];
                if (update_ras) ras_q[rb_sp_snap] <= actual_return_address;
            end else if (!mispredict && spec_push) begin
                ras_q[sp_q] <= spec_push_val;
            end
        end
    end
`else
    logic unused_ras;

    assign pd_sp_snap  = '0;
    assign pd_ras_snap = '0;
    assign unused_ras  = ^{restore_ras, rb_sp_snap, rb_ras_snap, actual_return_address,
                           spec_push, spec_pop, spec_push_val};
`endif

    // Per-slot lookup of BTB, PHT and (for returns) the RAS top
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            slot_pc[s]     = pc_q + XLEN'(4 * s);
            slot_bidx[s]   = slot_pc[s][5:2];
            slot_hit[s]    = btb_valid_q[slot_bidx[s]] &&
                             (btb_tag_q[slot_bidx[s]] == slot_pc[s][XLEN-1:6]);
            slot_type[s]   = btb_type_q[slot_bidx[s]];
            slot_pidx[s]   = slot_pc[s][PHT_ADDRESS+1:2] ^ ghr_q;
            slot_ctr_hi[s] = pht_q[slot_pidx[s]][1];
            slot_taken[s]  = slot_hit[s] && ((slot_type[s] != BT_BR) || slot_ctr_hi[s]);
            if (!slot_hit[s])                slot_tgt[s] = '0;
`ifdef PD_RAS_EN
            else if (slot_type[s] == BT_RET) slot_tgt[s] = ras_top;
`endif
            else                             slot_tgt[s] = btb_tgt_q[slot_bidx[s]];
        end
    end

    // Speculative history/RAS effects of slots up to and including the first taken one
    always_comb begin
        logic done;
        done          = 1'b0;
        ghr_spec      = ghr_q;
        spec_push     = 1'b0;
        spec_pop      = 1'b0;
        spec_push_val = '0;
        for (int s = 0; s < 2; s++) begin
            if (!done) begin
                if (slot_hit[s] && slot_type[s] == BT_BR)
                    ghr_spec = {ghr_spec[GHR_SIZE-2:0], slot_ctr_hi[s]};
                if (slot_hit[s] && slot_type[s] == BT_CALL) begin
                    spec_push     = 1'b1;
                    spec_push_val = slot_pc[s] + XLEN'(4);
                end
                if (slot_hit[s] && slot_type[s] == BT_RET) spec_pop = 1'b1;
                done = slot_taken[s];
            end
        end
    end

    // Next fetch PC and next global history
    always_comb begin
        if (mispredict)         pc_d = actual_target_address;
        else if (slot_taken[0]) pc_d = slot_tgt[0];
        else if (slot_taken[1]) pc_d = slot_tgt[1];
        else                    pc_d = pc_q + XLEN'(8);
        if (restore_ghr)        ghr_d = ex_is_branch ? {ghr_snap[GHR_SIZE-2:0], actual_taken} : ghr_snap;
        else if (!mispredict)   ghr_d = ghr_spec;
        else                    ghr_d = ghr_q;
    end

    assign btb_wr_type = ex_is_branch ? BT_BR : ex_is_ret ? BT_RET : update_ras ? BT_CALL : BT_JUMP;

    // Fetch PC and history registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            ghr_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ghr_q <= ghr_d;
        end
    end

    // BTB write from EX resolution
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_tag_q[i]   <= '0;
                btb_tgt_q[i]   <= '0;
                btb_type_q[i]  <= BT_BR;
            end
        end else if (update_btb) begin
            btb_valid_q[ex_pc[5:2]] <= 1'b1;
            btb_tag_q[ex_pc[5:2]]   <= ex_pc[XLEN-1:6];
            btb_tgt_q[ex_pc[5:2]]   <= actual_target_address;
            btb_type_q[ex_pc[5:2]]  <= btb_wr_type;
        end
    end

    // PHT training with 2-bit saturating counters, reset to weakly not-taken
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
        end else if (update_pht) begin
            if (actual_taken && pht_q[rb_pht_index] != 2'b11)
                pht_q[rb_pht_index] <= pht_q[rb_pht_index] + 2'd1;
            else if (!actual_taken && pht_q[rb_pht_index] != 2'b00)
                pht_q[rb_pht_index] <= pht_q[rb_pht_index] - 2'd1;
        end
    end

    assign pd_pc           = pc_q;
    assign pd_btb_hit1     = slot_hit[0];
    assign pd_btb_hit2     = slot_hit[1];
    assign pd_pred_taken1  = slot_taken[0];
    assign pd_pred_taken2  = slot_taken[1];
    assign pd_pred_target1 = slot_tgt[0];
    assign pd_pred_target2 = slot_tgt[1];
    assign pd_pht_index1   = slot_pidx[0];
    assign pd_pht_index2   = slot_pidx[1];
    assign pd_prev_ghr     = ghr_q;
endmodule

// File: tb/tb_pd_stage.sv
// tb/tb_pd_stage.sv - randomized scoreboard bench for pd_stage
module tb_pd_stage;
`ifdef PD_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int B_BR = 0, B_JUMP = 1, B_CALL = 2, B_RET = 3;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        mispredict = 1'b0, actual_taken = 1'b0;
    logic [31:0] actual_target_address = '0, actual_return_address = '0, ex_pc = '0;
    logic        ex_is_branch = 1'b0, ex_is_ret = 1'b0;
    logic        update_pht = 1'b0, update_btb = 1'b0, update_ras = 1'b0;
    logic        restore_ghr = 1'b0, restore_ras = 1'b0;
    logic [8:0]  ghr_snap = '0, rb_pht_index = '0;
    logic [2:0]  rb_sp_snap = '0;
    logic [63:0] rb_ras_snap = '0;

    logic [31:0] pd_pc, pd_pred_target1, pd_pred_target2;
    logic        pd_btb_hit1, pd_btb_hit2, pd_pred_taken1, pd_pred_taken2;
    logic [8:0]  pd_pht_index1, pd_pht_index2, pd_prev_ghr;
    logic [2:0]  pd_sp_snap;
    logic [63:0] pd_ras_snap;

    pd_stage #(.PHT_ADDRESS(9), .GHR_SIZE(9), .XLEN(32), .RAS_ADDRESS(3)) dut (
        .CLK(CLK), .reset(reset), .mispredict(mispredict), .actual_taken(actual_taken),
        .actual_target_address(actual_target_address), .actual_return_address(actual_return_address),
        .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_is_ret(ex_is_ret),
        .update_pht(update_pht), .update_btb(update_btb), .update_ras(update_ras),
        .restore_ghr(restore_ghr), .restore_ras(restore_ras), .ghr_snap(ghr_snap),
        .rb_pht_index(rb_pht_index), .rb_sp_snap(rb_sp_snap), .rb_ras_snap(rb_ras_snap),
        .pd_pc(pd_pc), .pd_btb_hit1(pd_btb_hit1), .pd_btb_hit2(pd_btb_hit2),
        .pd_pred_taken1(pd_pred_taken1), .pd_pred_taken2(pd_pred_taken2),
        .pd_pred_target1(pd_pred_target1), .pd_pred_target2(pd_pred_target2),
        .pd_pht_index1(pd_pht_index1), .pd_pht_index2(pd_pht_index2),
        .pd_prev_ghr(pd_prev_ghr), .pd_sp_snap(pd_sp_snap), .pd_ras_snap(pd_ras_snap)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] pc;
        logic        h1, h2, t1, t2;
        logic [31:0] tg1, tg2;
        logic [8:0]  i1, i2, ghr;
        logic [2:0]  sp;
        logic [63:0] rs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [8:0]  m_ghr;
    logic [2:0]  m_sp;
    logic [31:0] m_ras [8];
    bit          m_bv [16];
    logic [31:0] m_bpc [16];
    logic [31:0] m_btgt [16];
    int          m_btype [16];
    int          m_pht [512];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_ghr = '0; m_sp = '0;
        for (int i = 0; i < 8; i++) m_ras[i] = '0;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 1'b0; m_bpc[i] = '0; m_btgt[i] = '0; m_btype[i] = B_BR;
        end
        for (int i = 0; i < 512; i++) m_pht[i] = 1;
    endtask

    task automatic predict(input logic [31:0] spc, output bit hit, output bit taken,
                           output logic [31:0] tgt, output logic [8:0] idx,
                           output int typ, output bit ctr_hi);
        int e;
        logic [2:0] top;
        e      = int'((spc >> 2) % 16);
        hit    = m_bv[e] && ((m_bpc[e] >> 6) == (spc >> 6));
        typ    = m_btype[e];
        idx    = 9'(spc >> 2) ^ m_ghr;
        ctr_hi = (m_pht[idx] >= 2);
        taken  = hit && (typ != B_BR || ctr_hi);
        top    = m_sp - 3'd1;
        if (!hit)                        tgt = '0;
        else if (typ == B_RET && RAS_EN) tgt = m_ras[top];
        else                             tgt = m_btgt[e];
    endtask

    task automatic step();
        exp_t e;
        bit h0, h1, tk0, tk1, c0, c1, push, pop;
        logic [31:0] tg0, tg1, npc, pv;
        logic [8:0] ix0, ix1, ng;
        logic [2:0] a, b;
        int ty0, ty1, be;
        if (!reset) model_reset();
        predict(m_pc, h0, tk0, tg0, ix0, ty0, c0);
        predict(m_pc + 32'd4, h1, tk1, tg1, ix1, ty1, c1);
        a = m_sp - 3'd1; b = m_sp - 3'd2;
        e.pc = m_pc; e.h1 = h0; e.h2 = h1; e.t1 = tk0; e.t2 = tk1;
        e.tg1 = tg0; e.tg2 = tg1; e.i1 = ix0; e.i2 = ix1; e.ghr = m_ghr;
        e.sp = RAS_EN ? m_sp : 3'd0;
        e.rs = RAS_EN ? {m_ras[a], m_ras[b]} : 64'd0;
        sb_q.push_back(e);
        if (reset) begin
            if (mispredict)   npc = actual_target_address;
            else if (tk0)     npc = tg0;
            else if (tk1)     npc = tg1;
            else              npc = m_pc + 32'd8;
            ng = m_ghr; push = 0; pop = 0; pv = '0;
            if (!mispredict) begin
                if (h0 && ty0 == B_BR)   ng = {ng[7:0], c0};
                if (h0 && ty0 == B_CALL) begin push = 1; pv = m_pc + 32'd4; end
                if (h0 && ty0 == B_RET)  pop = 1;
                if (!tk0) begin
                    if (h1 && ty1 == B_BR)   ng = {ng[7:0], c1};
                    if (h1 && ty1 == B_CALL) begin push = 1; pv = m_pc + 32'd8; end
                    if (h1 && ty1 == B_RET)  pop = 1;
                end
            end
            if (restore_ghr) ng = ex_is_branch ? {ghr_snap[7:0], actual_taken} : ghr_snap;
            if (RAS_EN) begin
                if (restore_ras) begin
                    a = rb_sp_snap - 3'd1; b = rb_sp_snap - 3'd2;
                    m_ras[a] = rb_ras_snap[63:32];
                    m_ras[b] = rb_ras_snap[31:0];
                    m_sp = rb_sp_snap;
                    if (update_ras) begin m_ras[m_sp] = actual_return_address; m_sp = m_sp + 3'd1; end
                    else if (ex_is_ret) m_sp = m_sp - 3'd1;
                end else if (!mispredict) begin
                    if (push)     begin m_ras[m_sp] = pv; m_sp = m_sp + 3'd1; end
                    else if (pop) m_sp = m_sp - 3'd1;
                end
            end
            if (update_pht) begin
                if (actual_taken && m_pht[rb_pht_index] < 3)       m_pht[rb_pht_index]++;
                else if (!actual_taken && m_pht[rb_pht_index] > 0) m_pht[rb_pht_index]--;
            end
            if (update_btb) begin
                be = int'((ex_pc >> 2) % 16);
                m_bv[be] = 1'b1; m_bpc[be] = ex_pc; m_btgt[be] = actual_target_address;
                m_btype[be] = ex_is_branch ? B_BR : ex_is_ret ? B_RET : update_ras ? B_CALL : B_JUMP;
            end
            m_pc = npc; m_ghr = ng;
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        mispredict = 0; actual_taken = 0; actual_target_address = '0; actual_return_address = '0;
        ex_pc = '0; ex_is_branch = 0; ex_is_ret = 0; update_pht = 0; update_btb = 0; update_ras = 0;
        restore_ghr = 0; restore_ras = 0; ghr_snap = '0; rb_pht_index = '0; rb_sp_snap = '0; rb_ras_snap = '0;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [25:0] tag;
        tag = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'($urandom_range(0, 3));
        return {tag, 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    // Monitor: every cycle the DUT presents a prediction, compare against the oldest expectation
    initial begin : monitor
        exp_t me;
        forever begin
            @(negedge CLK);
            #2;
            if (sb_q.size() > 0) begin
                me = sb_q.pop_front();
                chk("pd_pc",   64'(pd_pc),           64'(me.pc));
                chk("hit1",    64'(pd_btb_hit1),     64'(me.h1));
                chk("hit2",    64'(pd_btb_hit2),     64'(me.h2));
                chk("taken1",  64'(pd_pred_taken1),  64'(me.t1));
                chk("taken2",  64'(pd_pred_taken2),  64'(me.t2));
                chk("target1", 64'(pd_pred_target1), 64'(me.tg1));
                chk("target2", 64'(pd_pred_target2), 64'(me.tg2));
                chk("pht_idx1",64'(pd_pht_index1),   64'(me.i1));
                chk("pht_idx2",64'(pd_pht_index2),   64'(me.i2));
                chk("prev_ghr",64'(pd_prev_ghr),     64'(me.ghr));
                chk("sp_snap", 64'(pd_sp_snap),      64'(me.sp));
                chk("ras_snap",pd_ras_snap,          me.rs);
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic
    initial begin : driver
        logic [2:0] t1, t2, sp0;
        @(negedge CLK);
        step();
        chk("rst_pc",    64'(pd_pc), 64'd0);
        chk("rst_idx2",  64'(pd_pht_index2), 64'd1);
        reset = 1'b1;
        step();
        chk("seq_pc8",   64'(pd_pc), 64'd8);

        update_btb = 1; mispredict = 1; ex_pc = 32'h4; actual_target_address = 32'h4;
        step(); clear_inputs();
        chk("jump_pc",     64'(pd_pc), 64'h4);
        chk("jump_taken1", 64'(pd_pred_taken1), 64'd1);
        chk("jump_tgt1",   64'(pd_pred_target1), 64'h4);
        step(); step();
        chk("jump_loop",   64'(pd_pc), 64'h4);

        update_btb = 1; mispredict = 1; ex_pc = 32'h10; ex_is_branch = 1; actual_target_address = 32'h10;
        step(); clear_inputs();
        chk("br_weak_nt", 64'(pd_pred_taken1), 64'd0);
        repeat (2) begin
            mispredict = 1; actual_target_address = 32'h10; update_pht = 1; actual_taken = 1;
            rb_pht_index = 9'h4 ^ m_ghr;
            step(); clear_inputs();
        end
        chk("br_trained", 64'(pd_pred_taken1), 64'd1);
        step();
        chk("br_ghr_lsb", 64'(pd_prev_ghr[0]), 64'd1);

        t1 = m_sp - 3'd1; t2 = m_sp - 3'd2;
        update_btb = 1; ex_pc = 32'h20; actual_target_address = 32'h100; update_ras = 1;
        restore_ras = 1; rb_sp_snap = m_sp; rb_ras_snap = {m_ras[t1], m_ras[t2]};
        actual_return_address = 32'h24; mispredict = 1;
        step(); clear_inputs();
        update_btb = 1; ex_pc = 32'h100; ex_is_ret = 1; actual_target_address = 32'h200; mispredict = 1;
        step(); clear_inputs();
        mispredict = 1; actual_target_address = 32'h20;
        step(); clear_inputs();
        sp0 = m_sp;
        step();
        chk("call_pc", 64'(pd_pc), 64'h100);
`ifdef PD_RAS_EN
        chk("ret_tgt", 64'(pd_pred_target1), 64'h24);
`endif
        step();
`ifdef PD_RAS_EN
        chk("ret_sp", 64'(pd_sp_snap), 64'(sp0));
`endif

        restore_ghr = 1; ghr_snap = 9'h155; ex_is_branch = 1; actual_taken = 0;
        mispredict = 1; actual_target_address = 32'h400;
        step(); clear_inputs();
        chk("ghr_restore", 64'(pd_prev_ghr), 64'h0AA);

        restore_ras = 1; rb_sp_snap = 3'd4; rb_ras_snap = 64'hAAAAAAAA88888888;
        mispredict = 1; actual_target_address = 32'h400;
        step(); clear_inputs();
`ifdef PD_RAS_EN
        chk("ras_restore_sp",  64'(pd_sp_snap), 64'd4);
        chk("ras_restore_ent", pd_ras_snap, 64'hAAAAAAAA88888888);
`endif

        for (int i = 0; i < 1500; i++) begin
            reset                 = ($urandom_range(0, 299) != 0);
            mispredict            = ($urandom_range(0, 9) < 3);
            actual_target_address = rand_pc();
            actual_return_address = $urandom;
            ex_pc                 = rand_pc();
            ex_is_branch          = 1'($urandom_range(0, 1));
            ex_is_ret             = ($urandom_range(0, 4) == 0);
            update_ras            = ($urandom_range(0, 6) == 0);
            update_btb            = ($urandom_range(0, 9) < 4);
            update_pht            = 1'($urandom_range(0, 1));
            actual_taken          = 1'($urandom_range(0, 1));
            rb_pht_index          = ($urandom_range(0, 1) == 0) ? (9'(m_pc >> 2) ^ m_ghr) : 9'($urandom);
            restore_ghr           = ($urandom_range(0, 9) == 0);
            ghr_snap              = 9'($urandom);
            restore_ras           = ($urandom_range(0, 9) == 0);
            rb_sp_snap            = 3'($urandom);
            rb_ras_snap           = {$urandom, $urandom};
            step();
        end
        reset = 1'b1;
        clear_inputs();
        step();
        #3;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pd_stage.md
# pd_stage

Two-wide branch-prediction (PD) stage at the front of the out-of-order core. It holds the fetch PC and predicts the next fetch group for slots `pd_pc` and `pd_pc+4`. Prediction uses a gshare PHT, a direct-mapped BTB and a return-address stack (RAS). EX supplies resolution updates, history and RAS restoration, and misprediction redirects.

## Interface
- `PHT_ADDRESS`, 9: PHT index width; the PHT has 2^PHT_ADDRESS 2-bit counters.
- `GHR_SIZE`, 9: global history width; must equal `PHT_ADDRESS`.
- `XLEN`, 32: address width.
- `RAS_ADDRESS`, 3: RAS pointer width; the RAS has 2^RAS_ADDRESS entries.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mispredict` in 1: redirect fetch to `actual_target_address`.
- `actual_taken` in 1: resolved branch direction.
- `actual_target_address` in XLEN: correct next PC / BTB target.
- `actual_return_address` in XLEN: return address of a resolved call.
- `ex_pc` in XLEN: PC of the resolved instruction.
- `ex_is_branch` in 1: resolved instruction is a conditional branch.
- `ex_is_ret` in 1: resolved instruction is a return.
- `update_pht` in 1: train PHT counter `rb_pht_index`.
- `update_btb` in 1: write BTB entry for `ex_pc`.
- `update_ras` in 1: resolved instruction is a call; push `actual_return_address`.
- `restore_ghr` in 1: restore GHR from `ghr_snap`.
- `restore_ras` in 1: restore RAS from `rb_sp_snap`/`rb_ras_snap`.
- `ghr_snap` in GHR_SIZE: GHR snapshot taken before the branch.
- `rb_pht_index` in PHT_ADDRESS: PHT index of the resolved branch.
- `rb_sp_snap` in RAS_ADDRESS, `rb_ras_snap` in 2*XLEN: RAS snapshot.
- `pd_pc` out XLEN: current fetch-group PC.
- `pd_btb_hit1`/`pd_btb_hit2` out 1: BTB hit for slot 1 (`pd_pc`) / slot 2 (`pd_pc+4`).
- `pd_pred_taken1`/`2` out 1: predicted taken per slot.
- `pd_pred_target1`/`2` out XLEN: predicted target per slot.
- `pd_pht_index1`/`2` out PHT_ADDRESS: PHT index used per slot.
- `pd_prev_ghr` out GHR_SIZE: GHR before this group's speculative update.
- `pd_sp_snap` out RAS_ADDRESS: RAS pointer before this group.
- `pd_ras_snap` out 2*XLEN: RAS snapshot {entry[sp-1], entry[sp-2]}.

## Operation
- **BTB**
  - 16 entries, direct-mapped; index `pc[5:2]`, tag `pc[XLEN-1:6]`.
  - Each entry holds valid, tag, target and a 2-bit type: BR, JUMP, CALL or RET.
  - On `update_btb`, the type is BR if `ex_is_branch`, else RET if `ex_is_ret`, else CALL if `update_ras`, else JUMP.
  - Hit = valid && tag match.
- **PHT**
  - Index per slot = `slot_pc[PHT_ADDRESS+1:2] ^ ghr`.
  - Counters are saturating 2-bit; predict taken when bit[1] = 1.
  - When `update_pht` is set, the counter at `rb_pht_index` increments if `actual_taken`, else decrements, saturating at 0 and 3.
- **Per-slot prediction**
  - taken = hit && (type != BR || counter[1]).
  - target = RAS top (`entry[sp-1]`) for RET, else the BTB target.
  - Outputs are combinational from `pd_pc` and the table state.
- **Next PC** (priority order):
  1. `mispredict`: `actual_target_address`.
  2. Slot 1 taken: `pd_pred_target1`.
  3. Slot 2 taken: `pd_pred_target2`.
  4. Otherwise: `pd_pc + 8`.
- **Speculative updates** (skipped when `mispredict`), applied in slot order up to and including the first taken slot:
  - GHR shifts in the prediction bit for each BR hit.
  - CALL pushes `slot_pc+4`.
  - RET pops.
- **GHR restore**
  - `restore_ghr` loads `{ghr_snap[GHR_SIZE-2:0], actual_taken}` if `ex_is_branch`, else `ghr_snap`.
  - Restore overrides any speculative shift.
- **RAS restore**
  - `restore_ras` sets sp = `rb_sp_snap`, entry[sp-1] = `rb_ras_snap[2*XLEN-1:XLEN]`, entry[sp-2] = `rb_ras_snap[XLEN-1:0]`.
  - Then, if `update_ras`, push `actual_return_address`; else if `ex_is_ret`, pop.
  - Restore overrides speculative push/pop.
- **RAS pointer** arithmetic is modulo 2^RAS_ADDRESS. Overflow overwrites the oldest entry; underflow wraps. Neither is flagged.

## Timing
- All state updates on the rising `CLK` edge; table writes are visible the next cycle.
- A mispredict in cycle t gives `pd_pc = actual_target_address` in t+1.
- The prediction-to-redirect path is zero-cycle: a taken prediction in cycle t sets `pd_pc` in t+1.
- Reset (`reset` = 0, asynchronous):
  - `pd_pc` = 0, GHR = 0, sp = 0.
  - All RAS entries = 0.
  - All BTB valid bits = 0.
  - All PHT counters = 2'b01 (weakly not-taken).
  - Consequently hit/taken outputs = 0, `pd_pred_target1/2` = 0, `pd_pht_index1` = 0, `pd_pht_index2` = 1.
- A BTB or PHT write in the same cycle as a read of the same entry returns the old value.
- Simultaneous `restore_ghr` and `mispredict` are legal; both apply.

## Configuration
- `PD_RAS_EN` defined: RAS present as described.
- `PD_RAS_EN` undefined:
  - No RAS storage; RET targets come from the BTB target.
  - `pd_sp_snap` and `pd_ras_snap` are tied to 0.
  - `update_ras`, `restore_ras` and the snapshot inputs are ignored.

## Test plan
- Reset with all inputs 0 -> `pd_pc` = 0, all hits and taken = 0; the next cycle `pd_pc` = 8.
- `update_btb` = 1, `mispredict` = 1, `ex_pc` = 4, target = 4, JUMP type -> next cycle `pd_pc` = 4, `pd_btb_hit1` = 1, `pd_pred_taken1` = 1, target1 = 4; `pd_pc` stays 4 thereafter.
- BR entry at PC 0x10 with counter at 01 -> `pd_pred_taken1` = 0; after two `update_pht` taken writes at that index -> taken = 1 and GHR LSB = 1 the next cycle.
- CALL at 0x20 to 0x100, then RET at 0x100 in the BTB -> at pc 0x100 `pd_pred_target1` = 0x24 and sp returns to its prior value.
- `restore_ghr` with `ghr_snap` = 9'b101010101, `ex_is_branch` = 1, `actual_taken` = 0 -> `pd_prev_ghr` = 9'b010101010.
- `restore_ras` with sp snapshot 4 and `rb_ras_snap` = 64'hAAAAAAAA88888888 -> `pd_sp_snap` = 4, `pd_ras_snap` = 64'hAAAAAAAA88888888.
